// File: rtl/mem_pkg.sv
// Shared sizes, FSM states and cache entry layout for the mem_handle responder.
// Imported by mem_cache_array and mem_handle_responder.
package mem_pkg;

    localparam int ADDR_SIZE  = 23;
    localparam int DATA_SIZE  = 32;
    localparam int CACHE_BITS = 8;
    localparam int TAG_BITS   = ADDR_SIZE - CACHE_BITS;
    localparam int ENTRIES    = 1 << CACHE_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL,
        ST_MEMWR,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]  tag;
        logic                 valid;
        logic                 dirty;
        logic [DATA_SIZE-1:0] data;
    } cache_entry_t;

endpackage

// File: rtl/mem_cache_array.sv
// Direct-mapped word cache storage: synchronous-read tag/data RAM plus
// flop valid/dirty vectors. Ports: clock, reset, rd_en, wr_en, index,
// wr_entry (tag/valid/dirty/data to store), rd_entry (registered read result).
module mem_cache_array
    import mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [CACHE_BITS-1:0] index,
    input  cache_entry_t          wr_entry,
    output cache_entry_t          rd_entry
);

    logic [TAG_BITS-1:0]  tag_ram  [ENTRIES];
    logic [DATA_SIZE-1:0] data_ram [ENTRIES];
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   dirty_q;

    logic [TAG_BITS-1:0]  rd_tag;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_dirty;

    // RAM has no reset; valid bits alone make stale contents harmless.
    // The read register only updates on rd_en so it keeps describing
    // the looked-up victim while the FSM writes the same index.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_ram[index]  <= wr_entry.tag;
            data_ram[index] <= wr_entry.data;
        end else if (rd_en) begin
            rd_tag  <= tag_ram[index];
            rd_data <= data_ram[index];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            dirty_q  <= '0;
            rd_valid <= 1'b0;
            rd_dirty <= 1'b0;
        end else if (wr_en) begin
            valid_q[index] <= wr_entry.valid;
            dirty_q[index] <= wr_entry.dirty;
        end else if (rd_en) begin
            rd_valid <= valid_q[index];
            rd_dirty <= dirty_q[index];
        end
    end

    assign rd_entry = {rd_tag, rd_valid, rd_dirty, rd_data};

endmodule

// File: rtl/mem_handle_responder.sv
// Memory-side responder: bounds check, write-back word cache, backing port.
// Client: region_*, ptr, r_en/w_en, flags, data_store -> avail/done/data_load/err.
// Memory: mem_addr/read/write/wdata out, mem_rdata/valid/waitrequest in.
module mem_handle_responder
    import mem_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] region_begin,
    input  logic [ADDR_SIZE-1:0] region_end,
    input  logic [ADDR_SIZE-1:0] ptr,
    input  logic                 r_en,
    input  logic                 w_en,
    input  logic                 write_through,
    input  logic                 read_through,
    input  logic [DATA_SIZE-1:0] data_store,
    output logic                 avail,
    output logic                 done,
    output logic [DATA_SIZE-1:0] data_load,
    output logic                 err,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    input  logic                 mem_rdata_valid,
    input  logic                 mem_waitrequest
);

    state_t state_q, state_d;

    logic [ADDR_SIZE-1:0]  ptr_q, rbeg_q, rend_q;
    logic [DATA_SIZE-1:0]  wdata_q, data_load_q;
    logic                  r_q, w_q, wt_q, rt_q;
    logic                  err_q, issued_q;

    logic [TAG_BITS-1:0]   tag_q;
    logic [CACHE_BITS-1:0] idx_q;
    logic                  accept, hit, lookup_err;

    logic                  c_rd, c_wr;
    logic [CACHE_BITS-1:0] c_index;
    cache_entry_t          c_wentry;
    cache_entry_t          rd;

    assign tag_q  = ptr_q[ADDR_SIZE-1:CACHE_BITS];
    assign idx_q  = ptr_q[CACHE_BITS-1:0];
    assign accept = (state_q == ST_IDLE) && (r_en || w_en);
    assign hit    = rd.valid && (rd.tag == tag_q);

    assign lookup_err = (r_q && w_q)
                     || (ptr_q < rbeg_q)
                     || (ptr_q > rend_q);

    assign avail     = (state_q == ST_IDLE);
    assign done      = (state_q == ST_RESP);
    assign err       = done && err_q;
    assign data_load = data_load_q;

    mem_cache_array u_cache (
        .clock    (clock),
        .reset    (reset),
        .rd_en    (c_rd),
        .wr_en    (c_wr),
        .index    (c_index),
        .wr_entry (c_wentry),
        .rd_entry (rd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        c_rd      = 1'b0;
        c_wr      = 1'b0;
        c_index   = idx_q;
        c_wentry  = {tag_q, 1'b1, 1'b0, wdata_q};
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                c_index = ptr[CACHE_BITS-1:0];
                if (accept) begin
                    c_rd    = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_err) begin
                    state_d = ST_RESP;
                end else if (r_q) begin
                    // Bypass reads still take a dirty hit from the cache,
                    // since memory holds stale data for that word.
                    if (rt_q && !(hit && rd.dirty)) begin
                        state_d = ST_FILL;
                    end else if (hit) begin
                        state_d = ST_RESP;
                    end else if (rd.valid && rd.dirty) begin
                        state_d = ST_EVICT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (!wt_q) begin
                    if (!hit && rd.valid && rd.dirty) begin
                        state_d = ST_EVICT;
                    end else begin
                        c_wr     = 1'b1;
                        c_wentry = {tag_q, 1'b1, 1'b1, wdata_q};
                        state_d  = ST_RESP;
                    end
                end else begin
                    c_wr    = hit;
                    state_d = ST_MEMWR;
                end
            end
            ST_EVICT: begin
                mem_write = 1'b1;
                mem_addr  = {rd.tag, idx_q};
                mem_wdata = rd.data;
                if (!mem_waitrequest) begin
                    if (r_q) begin
                        state_d = ST_FILL;
                    end else begin
                        c_wr     = 1'b1;
                        c_wentry = {tag_q, 1'b1, 1'b1, wdata_q};
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_FILL: begin
                mem_addr = ptr_q;
                mem_read = !issued_q;
                if (issued_q && mem_rdata_valid) begin
                    c_wr     = !rt_q;
                    c_wentry = {tag_q, 1'b1, 1'b0, mem_rdata};
                    state_d  = ST_RESP;
                end
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = wdata_q;
                if (!mem_waitrequest) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            rbeg_q      <= '0;
            rend_q      <= '0;
            wdata_q     <= '0;
            r_q         <= 1'b0;
            w_q         <= 1'b0;
            wt_q        <= 1'b0;
            rt_q        <= 1'b0;
            err_q       <= 1'b0;
            issued_q    <= 1'b0;
            data_load_q <= '0;
        end else begin
            if (accept) begin
                ptr_q    <= ptr;
                rbeg_q   <= region_begin;
                rend_q   <= region_end;
                wdata_q  <= data_store;
                r_q      <= r_en;
                w_q      <= w_en;
                wt_q     <= write_through;
                rt_q     <= read_through;
                err_q    <= 1'b0;
                issued_q <= 1'b0;
            end
            if (state_q == ST_LOOKUP) begin
                if (lookup_err) begin
                    err_q       <= 1'b1;
                    data_load_q <= '0;
                end else if (r_q && state_d == ST_RESP) begin
                    data_load_q <= rd.data;
                end
            end
            // FILL first waits out waitrequest, then the data beat.
            if (state_q == ST_FILL) begin
                if (!issued_q && !mem_waitrequest) begin
                    issued_q <= 1'b1;
                end else if (issued_q && mem_rdata_valid) begin
                    data_load_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_handle_responder.md
Name: mem_handle_responder

Overview:
- Memory-side responder for the mem_handle client protocol. Accepts single-word read/write requests from one compute client.
- Bounds-checks each request against the client's declared region.
- Serves requests from a direct-mapped write-back word cache of 2^CACHE_BITS entries.
- Talks to backing memory (SDRAM controller) over a simple waitrequest-style word port; one outstanding access at a time.

Parameters:
- ADDR_SIZE, 23, word address width (from the shared package).
- DATA_SIZE, 32, data word width.
- CACHE_BITS, 8, cache index width; entry count is 2^CACHE_BITS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- region_begin  in  ADDR_SIZE  first legal word address for the client.
- region_end  in  ADDR_SIZE  last legal word address, inclusive.
- ptr  in  ADDR_SIZE  request address; sampled at accept.
- r_en  in  1  read request; sampled only while avail=1.
- w_en  in  1  write request; sampled only while avail=1.
- write_through  in  1  write also goes to memory; dirty bit stays clear.
- read_through  in  1  read bypasses the cache; no allocation.
- data_store  in  DATA_SIZE  write data; sampled at accept.
- avail  out  1  responder idle and able to accept a request.
- done  out  1  one-cycle completion pulse.
- data_load  out  DATA_SIZE  read result; valid while done=1.
- err  out  1  valid with done; request was out of region or illegal.
- mem_addr  out  ADDR_SIZE  backing memory address.
- mem_read  out  1  backing read request.
- mem_write  out  1  backing write request.
- mem_wdata  out  DATA_SIZE  backing write data.
- mem_rdata  in  DATA_SIZE  backing read data.
- mem_rdata_valid  in  1  mem_rdata valid this cycle.
- mem_waitrequest  in  1  memory stalls the current mem_read/mem_write.

Behaviour:
- Reset values: avail=1, done=0, err=0, data_load=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. All valid and dirty bits cleared; FSM returns to IDLE.
- Reset mid-operation: any in-flight memory command drops asynchronously and dirty data is lost.
- Accept: in IDLE, avail=1. A cycle with r_en|w_en high is the accept cycle N. The responder latches ptr, data_store, the two through flags and the region bounds, then issues the cache read for index ptr[CACHE_BITS-1:0].
- Address split: tag = ptr[ADDR_SIZE-1:CACHE_BITS] (15 bits at defaults).
- avail=0 from N+1 until the cycle after done.
- States: IDLE, LOOKUP, EVICT, FILL, MEMWR, RESP.
- LOOKUP (N+1), first matching rule wins:
  - r_en & w_en both high -> RESP with err=1, no access.
  - ptr<region_begin or ptr>region_end -> RESP with err=1, data_load=0, no memory traffic.
  - Read, read_through=1 -> FILL without allocation; a valid hit on a dirty entry is still served from the cache.
  - Read hit -> RESP.
  - Read miss, victim clean -> FILL.
  - Read miss, victim valid and dirty -> EVICT.
  - Write, write_through=0, hit -> update data, set dirty, go to RESP.
  - Write, write_through=0, miss -> EVICT if victim is dirty; otherwise overwrite the entry (tag, valid=1, dirty=1), go to RESP.
  - Write, write_through=1 -> if hit, update data and clear dirty; always go to MEMWR. A miss does not allocate.
- EVICT: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim data. Held stable until a cycle with mem_waitrequest=0, then:
  - read -> FILL;
  - write-back write -> install the new word dirty and go to RESP.
- FILL: mem_read=1 with mem_addr=ptr, held until mem_waitrequest=0. Then wait for mem_rdata_valid (any latency >=1).
  - If not read_through, install the word clean and valid.
  - data_load <= mem_rdata; go to RESP.
- MEMWR: mem_write=1 with ptr/data_store, held until mem_waitrequest=0, then RESP.
- RESP: done=1 for exactly one cycle; go to IDLE.
- Hit latency: done at N+2.
- data_load holds its last value outside done. err=0 on every non-error done.
- mem_read and mem_write are never high together.
- r_en/w_en while avail=0 are ignored.

Decomposition:
- Package mem_pkg holds ADDR_SIZE, DATA_SIZE, CACHE_BITS, TAG_BITS=ADDR_SIZE-CACHE_BITS, the responder state enum, and the cache entry struct {tag, valid, dirty, data}.
- One sub-module, mem_cache_array:
  - synchronous-read tag/data RAM;
  - flop-based valid/dirty vectors with async clear;
  - a single read/write port.

Test Plan:
- Reset asserted then released -> avail=1, done=0, err=0, mem_read=0, mem_write=0, data_load=0.
- Region [0,0x7FFFFF]; write ptr=0x000010, data 0xDEADBEEF, write_through=0 at N -> done at N+2, no mem_write. Then read 0x000010 -> done at N+2, data_load=0xDEADBEEF, no mem_read.
- Then read ptr=0x000110 (same index, tag 1) -> mem_write addr 0x000010 data 0xDEADBEEF; then mem_read 0x000110; memory returns 0x12345678 after 3 cycles -> done with data_load=0x12345678, err=0.
- Region [0x100,0x1FF], read ptr=0x200 -> done at N+2 with err=1, data_load=0, no memory traffic. r_en and w_en together -> err=1.
- Write-through write of 0xCAFEF00D to 0x000020 with mem_waitrequest high for 3 cycles -> mem_write held 4 cycles with stable addr and data; done on the following cycle; a subsequent cached read of 0x000020 misses and fetches.
- Reset asserted mid-FILL -> mem_read=0 immediately, avail=1. A read of a previously cached address then misses and issues mem_read.
